servo_pwm_decoder: RTL and testbench

- Receive-side counterpart of the servo PWM generator. Measures the high time and period of an incoming servo-style PWM pulse train on the 50 MHz system clock.
- Reports the measurement as clock counts, with a range check and loss-of-signal timeout.
- Used to loop back and verify the servo drive, and to read external RC/servo PWM sources. Sits between a board input pin and control logic or display logic.

---
 rtl/servo_pkg.sv | 16 +
 rtl/servo_pwm_decoder_if.sv | 23 ++
 rtl/pwm_width_to_angle.sv | 76 +++++++
 rtl/servo_pwm_decoder.sv | 167 ++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared types and nominal timing constants for the servo PWM path (50 MHz clock).
package servo_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        ARMED,
        HIGH,
        LOW
    } servo_state_e;

    localparam int SERVO_MIN_WIDTH = 20_000;
    localparam int SERVO_MAX_WIDTH = 120_000;
    localparam int SERVO_FRAME     = 1_000_000;
    localparam int SERVO_ANGLE_MAX = 180;

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Bus bundle between a PWM source/consumer (master) and the servo PWM decoder (slave).
interface servo_pwm_decoder_if #(
    parameter int CNT_W = 21
);
    logic             pwm_in;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             in_range;
    logic             timeout;
    logic [7:0]       angle;
    logic             angle_valid;

    modport master (
        output pwm_in,
        input  width, period, valid, in_range, timeout, angle, angle_valid
    );

    modport slave (
        input  pwm_in,
        output width, period, valid, in_range, timeout, angle, angle_valid
    );
endinterface

// File: rtl/pwm_width_to_angle.sv
// Iterative subtract-and-count conversion of a pulse width to degrees 0..180.
// Only present when ANGLE_OUT_EN is defined.
`ifdef ANGLE_OUT_EN
module pwm_width_to_angle
    import servo_pkg::*;
#(
    parameter int CNT_W      = 21,
    parameter int MIN_WIDTH  = SERVO_MIN_WIDTH,
    parameter int ANGLE_STEP = 555
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] width_in,
    output logic [7:0]       angle,
    output logic             angle_valid
);
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] STEP_CNT  = CNT_W'(ANGLE_STEP);
    localparam logic [7:0]       ANGLE_MAX = 8'(SERVO_ANGLE_MAX);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       angle_q, angle_d;
    logic             angle_valid_q, angle_valid_d;

    // A fresh start always wins, so a stale computation is simply overwritten.
    always_comb begin
        busy_d        = busy_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        angle_d       = angle_q;
        angle_valid_d = 1'b0;
        if (start) begin
            if (width_in < MIN_CNT) begin
                busy_d        = 1'b0;
                angle_d       = '0;
                angle_valid_d = 1'b1;
            end else begin
                busy_d = 1'b1;
                rem_d  = width_in - MIN_CNT;
                cnt_d  = '0;
            end
        end else if (busy_q) begin
            if (rem_q >= STEP_CNT && cnt_q < ANGLE_MAX) begin
                rem_d = rem_q - STEP_CNT;
                cnt_d = cnt_q + 8'd1;
            end else begin
                busy_d        = 1'b0;
                angle_d       = cnt_q;
                angle_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= 1'b0;
            rem_q         <= '0;
            cnt_q         <= '0;
            angle_q       <= '0;
            angle_valid_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
        end
    end

    assign angle       = angle_q;
    assign angle_valid = angle_valid_q;
endmodule
`endif

// File: rtl/servo_pwm_decoder.sv
// Measures high time and period of a servo PWM input with range check and loss-of-signal timeout.
// Define ANGLE_OUT_EN to add the width-to-degrees converter on angle/angle_valid.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CNT_W      = 21,
    parameter int MIN_WIDTH  = SERVO_MIN_WIDTH,
    parameter int MAX_WIDTH  = SERVO_MAX_WIDTH,
    parameter int TIMEOUT    = SERVO_FRAME + SERVO_FRAME / 2,
    parameter int ANGLE_STEP = (SERVO_MAX_WIDTH - SERVO_MIN_WIDTH) / SERVO_ANGLE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    servo_pwm_decoder_if.slave  bus
);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             sync1_q, sync2_q, prev_q;
    logic             rise, fall;
    servo_state_e     state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] width_rpt_q, width_rpt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             in_range_q, in_range_d;
    logic             timeout_q, timeout_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x >= TO_CNT) ? x : x + ONE;
    endfunction

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    // NOTE: every comb output gets its default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        pcnt_d      = pcnt_q;
        width_d     = width_q;
        width_rpt_d = width_rpt_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        in_range_d  = in_range_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            SYNC_WAIT: begin
                if (!sync2_q) begin
                    state_d = ARMED;
                    pcnt_d  = '0;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = ONE;
                    pcnt_d  = ONE;
                end else if (pcnt_q >= TO_CNT) begin
                    timeout_d = 1'b1;
                    pcnt_d    = '0;
                end else begin
                    pcnt_d = sat_inc(pcnt_q);
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d    = LOW;
                    width_d    = hcnt_q;
                    in_range_d = (hcnt_q >= MIN_CNT) && (hcnt_q <= MAX_CNT);
                    pcnt_d     = sat_inc(pcnt_q);
                end else if (hcnt_q >= TO_CNT) begin
                    state_d   = SYNC_WAIT;
                    timeout_d = 1'b1;
                end else begin
                    hcnt_d = sat_inc(hcnt_q);
                    pcnt_d = sat_inc(pcnt_q);
                end
            end
            LOW: begin
                // Rise is tested first: it beats a timeout landing on the same cycle.
                if (rise) begin
                    state_d     = HIGH;
                    width_rpt_d = width_q;
                    period_d    = pcnt_q;
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    hcnt_d      = ONE;
                    pcnt_d      = ONE;
                end else if (pcnt_q >= TO_CNT) begin
                    state_d   = ARMED;
                    timeout_d = 1'b1;
                    pcnt_d    = '0;
                end else begin
                    pcnt_d = sat_inc(pcnt_q);
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchroniser resets to "high" so a pulse already in progress
            // at reset release is waited out in SYNC_WAIT instead of being seen as a rise.
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= SYNC_WAIT;
            hcnt_q      <= '0;
            pcnt_q      <= '0;
            width_q     <= '0;
            width_rpt_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            in_range_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= bus.pwm_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            pcnt_q      <= pcnt_d;
            width_q     <= width_d;
            width_rpt_q <= width_rpt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            in_range_q  <= in_range_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.width    = width_rpt_q;
    assign bus.period   = period_q;
    assign bus.valid    = valid_q;
    assign bus.in_range = in_range_q;
    assign bus.timeout  = timeout_q;

`ifdef ANGLE_OUT_EN
    logic angle_start;
    assign angle_start = (state_q == HIGH) && fall;

    pwm_width_to_angle #(
        .CNT_W      (CNT_W),
        .MIN_WIDTH  (MIN_WIDTH),
        .ANGLE_STEP (ANGLE_STEP)
    ) u_angle (
        .clk         (clk),
        .rst         (rst),
        .start       (angle_start),
        .width_in    (hcnt_q),
        .angle       (bus.angle),
        .angle_valid (bus.angle_valid)
    );
`else
    logic unused_angle_step;
    assign unused_angle_step = (ANGLE_STEP > 0);
    assign bus.angle         = '0;
    assign bus.angle_valid   = 1'b0;
`endif
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder using scaled-down timing parameters.
module tb_servo_pwm_decoder;
    localparam int CNT_W = 13;
    localparam int MIN_W = 200;
    localparam int MAX_W = 2000;
    localparam int TO    = 4000;
    localparam int STEP  = 10;

    typedef struct {
        int high;
        int period;
        bit chk;
        int exp_w;
        int exp_p;
        bit exp_r;
        int exp_a;
    } row_t;

    typedef struct {
        int w;
        int p;
        bit r;
        bit t;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ang_cnt = 0;
    ev_t  ev_q[$];
    int   ang_q[$];

    servo_pwm_decoder_if #(.CNT_W(CNT_W)) bus();

    servo_pwm_decoder #(
        .CNT_W      (CNT_W),
        .MIN_WIDTH  (MIN_W),
        .MAX_WIDTH  (MAX_W),
        .TIMEOUT    (TO),
        .ANGLE_STEP (STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.valid)
            ev_q.push_back('{int'(bus.width), int'(bus.period), bus.in_range, bus.timeout});
        if (bus.angle_valid) begin
            ang_q.push_back(int'(bus.angle));
            ang_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int n);
        bus.pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int h, input int p);
        drive(1'b1, h);
        drive(1'b0, p - h);
    endtask

    task automatic check_ev(input string name, input int w, input int p, input bit r);
        ev_t e;
        check({name, "_nvalid"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            check({name, "_width"}, e.w, w);
            check({name, "_period"}, e.p, p);
            check({name, "_in_range"}, int'(e.r), int'(r));
            check({name, "_timeout_at_valid"}, int'(e.t), 0);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_width"}, int'(bus.width), 0);
        check({name, "_period"}, int'(bus.period), 0);
        check({name, "_valid"}, int'(bus.valid), 0);
        check({name, "_in_range"}, int'(bus.in_range), 0);
        check({name, "_timeout"}, int'(bus.timeout), 0);
        check({name, "_angle"}, int'(bus.angle), 0);
        check({name, "_angle_valid"}, int'(bus.angle_valid), 0);
    endtask

    initial begin
        row_t rows[9];
        rows[0] = '{750,  3000, 1'b0, 0,    0,    1'b0, 55};
        rows[1] = '{750,  3000, 1'b1, 750,  3000, 1'b1, 55};
        rows[2] = '{750,  3000, 1'b1, 750,  3000, 1'b1, 55};
        rows[3] = '{200,  3000, 1'b1, 750,  3000, 1'b1, 0};
        rows[4] = '{2000, 3000, 1'b1, 200,  3000, 1'b1, 180};
        rows[5] = '{100,  2500, 1'b1, 2000, 3000, 1'b1, 0};
        rows[6] = '{199,  3000, 1'b1, 100,  2500, 1'b0, 0};
        rows[7] = '{2100, 3000, 1'b1, 199,  3000, 1'b0, 180};
        rows[8] = '{300,  3000, 1'b1, 2100, 3000, 1'b0, 10};

        bus.pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Idle low input: only the loss-of-signal flag may appear.
        repeat (TO - 20) @(negedge clk);
        check("idle_early_timeout", int'(bus.timeout), 0);
        repeat (40) @(negedge clk);
        check("idle_timeout", int'(bus.timeout), 1);
        repeat (TO - 20) @(negedge clk);
        check("idle_nvalid", ev_q.size(), 0);
        check("idle_timeout_sticky", int'(bus.timeout), 1);

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            frame(rows[i].high, rows[i].period);
            if (rows[i].chk)
                check_ev(tag, rows[i].exp_w, rows[i].exp_p, rows[i].exp_r);
            else
                check({tag, "_nvalid"}, ev_q.size(), 0);
            check({tag, "_timeout"}, int'(bus.timeout), rows[i].chk ? 0 : 1);
            check({tag, "_in_range_now"}, int'(bus.in_range),
                  (rows[i].high >= MIN_W && rows[i].high <= MAX_W) ? 1 : 0);
`ifdef ANGLE_OUT_EN
            check({tag, "_nangle"}, ang_q.size(), 1);
            if (ang_q.size() > 0)
                check({tag, "_angle"}, ang_q.pop_front(), rows[i].exp_a);
`endif
        end
        ev_q.delete();
        ang_q.delete();

        // Reset released in the middle of a high pulse: that pulse is discarded.
        rst = 1'b1;
        bus.pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("midpulse_reset");
        rst = 1'b0;
        drive(1'b1, 500);
        drive(1'b0, 2500);
        check("midpulse_partial_nvalid", ev_q.size(), 0);
        frame(750, 3000);
        check("midpulse_first_nvalid", ev_q.size(), 0);
        frame(750, 3000);
        check_ev("midpulse_second", 750, 3000, 1'b1);

        // Input stuck high after a good frame.
        drive(1'b1, 2 * TO);
        check_ev("stuck_close", 750, 3000, 1'b1);
        check("stuck_timeout", int'(bus.timeout), 1);
        check("stuck_width_kept", int'(bus.width), 750);
        check("stuck_period_kept", int'(bus.period), 3000);
        drive(1'b0, 1000);
        frame(750, 3000);
        check("recover_first_nvalid", ev_q.size(), 0);
        check("recover_first_timeout", int'(bus.timeout), 1);
        frame(750, 3000);
        check_ev("recover_second", 750, 3000, 1'b1);
        check("recover_timeout_cleared", int'(bus.timeout), 0);

        // One-cycle reset in the middle of a high pulse.
        drive(1'b1, 300);
        check_ev("rst_high_close", 750, 3000, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("rst_high");
        drive(1'b1, 449);
        drive(1'b0, 2250);
        check("rst_high_rest_nvalid", ev_q.size(), 0);
        frame(750, 3000);
        check("rst_high_first_nvalid", ev_q.size(), 0);
        frame(750, 3000);
        check_ev("rst_high_second", 750, 3000, 1'b1);

`ifndef ANGLE_OUT_EN
        check("no_angle_strobes", ang_cnt, 0);
        check("angle_tied_low", int'(bus.angle), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
